// File: rtl/iter_sll32.sv
// Multi-cycle logical left shifter: one barrel stage (16, 8, 4, 2, 1) per clock.
// Define ITER_SLL_SKIP_EN to skip stages whose shift-amount bit is clear.
module iter_sll32 #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned SHAMT_BITS = 5
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      data_in,
   input  logic [SHAMT_BITS-1:0] shamt,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      data_out
);

   localparam int unsigned StageW = (SHAMT_BITS > 1) ? $clog2(SHAMT_BITS) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state;
   logic [StageW-1:0]     stage;
   logic [SHAMT_BITS-1:0] shamt_r;
   logic [SHAMT_BITS-1:0] step;
   logic [StageW-1:0]     first_stage;
   logic [StageW-1:0]     next_stage;
   logic                  last;

   assign busy = (state == SHIFT);
   assign step = {{(SHAMT_BITS-1){1'b0}}, 1'b1} << stage;

`ifdef ITER_SLL_SKIP_EN
   // Returns {found, index} of the highest set bit, optionally restricted below limit.
   function automatic logic [StageW:0] highest_set(input logic [SHAMT_BITS-1:0] bits,
                                                   input logic                  bounded,
                                                   input logic [StageW-1:0]     limit);
      logic [StageW:0] res;
      res = '0;
      for (int unsigned i = 0; i < SHAMT_BITS; i++) begin
         if (bits[i] && (!bounded || (StageW'(i) < limit))) begin
            res = {1'b1, StageW'(i)};
         end
      end
      return res;
   endfunction

   logic [StageW:0] hi_all;
   logic [StageW:0] hi_below;

   assign hi_all      = highest_set(shamt, 1'b0, '0);
   assign hi_below    = highest_set(shamt_r, 1'b1, stage);
   // shamt==0 lands on stage 0 with a clear bit: one pass-through cycle.
   assign first_stage = hi_all[StageW-1:0];
   assign next_stage  = hi_below[StageW-1:0];
   assign last        = !hi_below[StageW];
`else
   assign first_stage = StageW'(SHAMT_BITS - 1);
   assign next_stage  = stage - StageW'(1);
   assign last        = (stage == '0);
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         stage    <= '0;
         shamt_r  <= '0;
         done     <= 1'b0;
         data_out <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  data_out <= data_in;
                  shamt_r  <= shamt;
                  stage    <= first_stage;
                  state    <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               if (shamt_r[stage]) begin
                  data_out <= data_out << step;
               end
               if (last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  stage <= next_stage;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_sll32.sv
// Directed self-checking bench for iter_sll32; honours ITER_SLL_SKIP_EN for latency expectations.
module tb_iter_sll32;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [31:0] data_in;
   logic [4:0]  shamt;
   logic        busy;
   logic        done;
   logic [31:0] data_out;

   int checks;
   int failures;

   iter_sll32 dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .data_in (data_in),
      .shamt   (shamt),
      .busy    (busy),
      .done    (done),
      .data_out(data_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int exp_lat(input logic [4:0] s);
`ifdef ITER_SLL_SKIP_EN
      return ($countones(s) == 0) ? 1 : $countones(s);
`else
      return 5;
`endif
   endfunction

   // Issue one op and wait (bounded) until done is seen; returns in the done cycle.
   task automatic run_op(input logic [31:0] d, input logic [4:0] s,
                         output int lat, output int bcnt, output logic first_busy);
      data_in = d;
      shamt   = s;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      data_in = 32'hDEAD_BEEF;
      shamt   = 5'h1F;
      first_busy = busy;
      lat  = 0;
      bcnt = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) bcnt++;
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b0;
      data_in = 32'h0;
      shamt   = 5'h0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL reset_done: got %b expected 0", done);
      end
      checks++;
      if (data_out !== 32'h0) begin
         failures++;
         $display("FAIL reset_data: got %h expected 00000000", data_out);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_sll_31();
      int lat, bcnt;
      logic fb;
      run_op(32'h0000_0001, 5'd31, lat, bcnt, fb);
      checks++;
      if (data_out !== 32'h8000_0000) begin
         failures++;
         $display("FAIL sll31_data: got %h expected 80000000", data_out);
      end
      checks++;
      if (lat != 5) begin
         failures++;
         $display("FAIL sll31_latency: got %0d expected 5", lat);
      end
      checks++;
      if (bcnt != 5) begin
         failures++;
         $display("FAIL sll31_busy_cycles: got %0d expected 5", bcnt);
      end
      checks++;
      if (fb !== 1'b1) begin
         failures++;
         $display("FAIL sll31_first_busy: got %b expected 1", fb);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL sll31_done_pulse: got %b expected 0", done);
      end
   endtask

   task automatic test_sll_16();
      int lat, bcnt;
      logic fb;
      run_op(32'hFFFF_FFFF, 5'd16, lat, bcnt, fb);
      checks++;
      if (data_out !== 32'hFFFF_0000) begin
         failures++;
         $display("FAIL sll16_data: got %h expected ffff0000", data_out);
      end
      checks++;
      if (lat != exp_lat(5'd16)) begin
         failures++;
         $display("FAIL sll16_latency: got %0d expected %0d", lat, exp_lat(5'd16));
      end
      tick();
   endtask

   task automatic test_shamt_zero();
      int lat, bcnt;
      logic fb;
      run_op(32'h1234_5678, 5'd0, lat, bcnt, fb);
      checks++;
      if (data_out !== 32'h1234_5678) begin
         failures++;
         $display("FAIL zero_data: got %h expected 12345678", data_out);
      end
      checks++;
      if (lat != exp_lat(5'd0)) begin
         failures++;
         $display("FAIL zero_latency: got %0d expected %0d", lat, exp_lat(5'd0));
      end
      tick();
   endtask

   task automatic test_ignore_busy();
      int dcnt;
      logic [31:0] res;
      data_in = 32'h0000_00FF;
      shamt   = 5'd4;
      start   = 1'b1;
      tick();
      start   = 1'b0;
`ifndef ITER_SLL_SKIP_EN
      tick();
`endif
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL ignore_busy_state: got %b expected 1", busy);
      end
      data_in = 32'hAAAA_AAAA;
      shamt   = 5'd1;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      dcnt = 0;
      res  = 32'h0;
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1) begin
            dcnt++;
            res = data_out;
         end
         tick();
      end
      checks++;
      if (dcnt != 1) begin
         failures++;
         $display("FAIL ignore_done_count: got %0d expected 1", dcnt);
      end
      checks++;
      if (res !== 32'h0000_0FF0) begin
         failures++;
         $display("FAIL ignore_data: got %h expected 00000ff0", res);
      end
   endtask

   task automatic test_reset_mid();
      int dcnt, lat, bcnt;
      logic fb;
      data_in = 32'h0000_0003;
      shamt   = 5'd8;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      tick();
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL midreset_busy: got %b expected 0", busy);
      end
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL midreset_done: got %b expected 0", done);
      end
      checks++;
      if (data_out !== 32'h0) begin
         failures++;
         $display("FAIL midreset_data: got %h expected 00000000", data_out);
      end
      tick();
      tick();
      reset_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done === 1'b1) dcnt++;
      end
      checks++;
      if (dcnt != 0) begin
         failures++;
         $display("FAIL midreset_stray_done: got %0d expected 0", dcnt);
      end
      run_op(32'h0000_0001, 5'd1, lat, bcnt, fb);
      checks++;
      if (data_out !== 32'h0000_0002 || lat >= 20) begin
         failures++;
         $display("FAIL midreset_new_op: got %h (lat %0d) expected 00000002", data_out, lat);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat, bcnt;
      logic fb;
      run_op(32'h0000_0001, 5'd2, lat, bcnt, fb);
      checks++;
      if (data_out !== 32'h0000_0004) begin
         failures++;
         $display("FAIL b2b_first_data: got %h expected 00000004", data_out);
      end
      // Still in the DONE cycle: the next request is issued with no gap.
      run_op(32'h0000_0010, 5'd3, lat, bcnt, fb);
      checks++;
      if (fb !== 1'b1) begin
         failures++;
         $display("FAIL b2b_busy_next: got %b expected 1", fb);
      end
      checks++;
      if (data_out !== 32'h0000_0080) begin
         failures++;
         $display("FAIL b2b_second_data: got %h expected 00000080", data_out);
      end
      checks++;
      if (lat != exp_lat(5'd3)) begin
         failures++;
         $display("FAIL b2b_latency: got %0d expected %0d", lat, exp_lat(5'd3));
      end
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_sll_31();
      test_sll_16();
      test_shamt_zero();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
